// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped input bank on the shared ABUS/DBUS/WE bus.
// Each channel is synchronised, polarity-corrected and debounced. Qualified
// transitions are latched into sticky EDGE bits, and OVF tracks lost edges.
// Optional feature macro IO_INPUT_IRQ_EN adds the IRQ output and the CTRL.IE bit.
// Register map (16-byte window): 0x0 DATA, 0x4 CTRL, 0x8 EDGE (W1C), 0xC OVF (W1C).
module io_input_bank #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] BASE            = 32'hF0000040,
  parameter int unsigned      N_CH            = 4,
  parameter logic [N_CH-1:0]  INV_MASK        = '0,
  parameter int unsigned      DEBOUNCE_CYCLES = 16,
  parameter int unsigned      DB_BITS         = 16
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic [DBITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] DBUS,
  input  logic             WE,
  input  logic [N_CH-1:0]  PINS
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic             IRQ
`endif
);

  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

  logic               sel;
  logic [1:0]         offset;
  logic               wr;
  logic               rd;
  logic [N_CH-1:0]    sync1;
  logic [N_CH-1:0]    sync2;
  logic [N_CH-1:0]    deb;
  logic [DB_BITS-1:0] cnt [N_CH];
  logic [N_CH-1:0]    qual;
  logic [N_CH-1:0]    ev_next;
  logic [N_CH-1:0]    ev;
  logic [2:0]         ctrl;
  logic               ie_in;
  logic [N_CH-1:0]    edge_pend;
  logic [N_CH-1:0]    ovf_pend;
  logic [N_CH-1:0]    w1c_edge;
  logic [N_CH-1:0]    w1c_ovf;
  logic [DBITS-1:0]   rdata;
  logic               unused_bits;

  assign sel    = (ABUS[DBITS-1:4] == BASE[DBITS-1:4]);
  assign offset = ABUS[3:2];
  assign wr     = sel & WE;
  assign rd     = sel & ~WE & reset_n;

  assign w1c_edge = (wr && offset == 2'd2) ? DBUS[N_CH-1:0] : '0;
  assign w1c_ovf  = (wr && offset == 2'd3) ? DBUS[N_CH-1:0] : '0;

`ifdef IO_INPUT_IRQ_EN
  assign ie_in = DBUS[0];
`else
  assign ie_in = 1'b0;
`endif

  assign unused_bits = ^{ABUS[1:0], DBUS};

  // Two-stage synchroniser on the polarity-corrected pins.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= PINS ^ INV_MASK;
      sync2 <= sync1;
    end
  end

  // A channel qualifies when it has disagreed with deb for DEBOUNCE_CYCLES edges.
  always_comb begin
    qual = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      qual[i] = (sync2[i] != deb[i]) && (cnt[i] == DB_LAST);
    end
  end

  // Select which qualified transitions count as events for the current MODE.
  always_comb begin
    ev_next = qual & sync2;
    if (ctrl[2]) begin
      ev_next = qual;
    end else if (ctrl[1]) begin
      ev_next = qual & ~sync2;
    end
  end

  // Per-channel debounce counters and debounced state; ev is registered so
  // EDGE is set on the edge after deb changes.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      ev  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb <= deb ^ qual;
      ev  <= ev_next;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (sync2[i] == deb[i] || qual[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_BITS'(1);
        end
      end
    end
  end

  // CTRL register plus sticky EDGE/OVF; a new event beats a same-cycle W1C,
  // and an edge cleared in that cycle does not count as an overflow.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ctrl      <= '0;
      edge_pend <= '0;
      ovf_pend  <= '0;
    end else begin
      if (wr && offset == 2'd1) begin
        ctrl <= {DBUS[2:1], ie_in};
      end
      ovf_pend  <= (ovf_pend & ~w1c_ovf) | (ev & edge_pend & ~w1c_edge);
      edge_pend <= (edge_pend & ~w1c_edge) | ev;
    end
  end

`ifdef IO_INPUT_IRQ_EN
  // Registered interrupt request: enabled and anything pending.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= ctrl[0] & (|edge_pend);
    end
  end
`endif

  // Read mux; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      2'd0:    rdata[N_CH-1:0] = deb;
      2'd1:    rdata[2:0]      = ctrl;
      2'd2:    rdata[N_CH-1:0] = edge_pend;
      default: rdata[N_CH-1:0] = ovf_pend;
    endcase
  end

  assign DBUS = rd ? rdata : 'z;

endmodule
